// File: rtl/ppu_pkg.sv
// ppu_pkg
// Shared definitions for the PPU VRAM arbiter slice.
//   state_t            : arbiter FSM state encodings (S_IDLE..S_CPU_RD_CAP)
//   DEFAULT_ADDR_MASK  : default 14-bit VRAM address space mask
//   INC_SMALL/INC_LARGE: $2007 auto-increment step sizes (1 and 32)
package ppu_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_CPU_WR     = 2'd1,
    S_CPU_RD     = 2'd2,
    S_CPU_RD_CAP = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_ADDR_MASK = 16'h3FFF;
  localparam logic [15:0] INC_SMALL         = 16'd1;
  localparam logic [15:0] INC_LARGE         = 16'd32;

  // Next CPU VRAM address after a $2007 access.
  function automatic logic [15:0] next_vaddr(input logic [15:0] vaddr,
                                             input logic        big,
                                             input logic [15:0] inc_big,
                                             input logic [15:0] mask);
    return (vaddr + (big ? inc_big : INC_SMALL)) & mask;
  endfunction

endpackage

// File: rtl/ppu_cpu_addr_latch.sv
// ppu_cpu_addr_latch
// CPU-side VRAM address register: $2006 two-write toggle, $2002 toggle clear
// and the $2007 auto-increment with wrap.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   addr_wr         : accepted $2006 write (already arbitrated by the parent)
//   status_rd       : $2002 read, clears the write toggle
//   wdata [7:0]     : $2006 write byte
//   inc_big_sel     : select the large increment step
//   advance         : step the address after a completed $2007 access
//   vaddr [15:0]    : current CPU VRAM address
//   w               : current write toggle (1 = next $2006 write is the low byte)
module ppu_cpu_addr_latch
  import ppu_pkg::*;
#(
  parameter logic [15:0] ADDR_MASK = DEFAULT_ADDR_MASK,
  parameter logic [15:0] INC_BIG   = INC_LARGE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_wr,
  input  logic        status_rd,
  input  logic [7:0]  wdata,
  input  logic        inc_big_sel,
  input  logic        advance,
  output logic [15:0] vaddr,
  output logic        w
);

  logic [15:0] vaddr_reg;
  logic [15:0] vaddr_next;
  logic        w_reg;
  logic        w_next;
  logic        w_eff;

  // A $2002 read in the same cycle as a $2006 write clears the toggle first,
  // so that write is always taken as the high byte.
  assign w_eff = status_rd ? 1'b0 : w_reg;

  always_comb begin
    vaddr_next = vaddr_reg;
    w_next     = w_eff;
    if (addr_wr) begin
      if (!w_eff) begin
        vaddr_next = {2'b00, wdata[5:0], vaddr_reg[7:0]} & ADDR_MASK;
        w_next     = 1'b1;
      end else begin
        vaddr_next = {vaddr_reg[15:8], wdata} & ADDR_MASK;
        w_next     = 1'b0;
      end
    end else if (advance) begin
      vaddr_next = next_vaddr(vaddr_reg, inc_big_sel, INC_BIG, ADDR_MASK);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vaddr_reg <= 16'h0000;
      w_reg     <= 1'b0;
    end else begin
      vaddr_reg <= vaddr_next;
      w_reg     <= w_next;
    end
  end

  assign vaddr = vaddr_reg;
  assign w     = w_reg;

endmodule

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter
// Shares one synchronous-read VRAM between the PPU render path and the CPU
// $2006/$2007 port. The PPU always wins while idle; CPU accesses are queued
// in a one-entry pending slot and, once started, run to completion.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   ppu_req/ppu_addr/ppu_grant    : PPU read request, address, same-cycle grant
//   cpu_addr_wr/cpu_data_wr/
//   cpu_data_rd/cpu_status_rd     : CPU register strobes ($2006/$2007 W/$2007 R/$2002 R)
//   cpu_wdata                     : CPU write byte
//   ppu_ctrl1                     : bit 2 selects the large $2007 increment
//   cpu_rdata                     : $2007 read buffer
//   cpu_busy                      : CPU VRAM operation pending or in flight
//   cpu_overrun                   : sticky, a CPU strobe was dropped
//   cpu_vaddr                     : CPU VRAM address (visibility)
//   vram_addr/vram_we/
//   vram_data_out/vram_data_in    : VRAM macro interface (read data one cycle late)
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter logic [15:0] ADDR_MASK = DEFAULT_ADDR_MASK,
  parameter logic [15:0] INC_BIG   = INC_LARGE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ppu_req,
  input  logic [15:0] ppu_addr,
  output logic        ppu_grant,
  input  logic        cpu_addr_wr,
  input  logic        cpu_data_wr,
  input  logic        cpu_data_rd,
  input  logic        cpu_status_rd,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  ppu_ctrl1,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_busy,
  output logic        cpu_overrun,
  output logic [15:0] cpu_vaddr,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_data_out,
  input  logic [7:0]  vram_data_in
);

  state_t      state_reg;
  state_t      state_next;
  logic        pend_valid_reg;
  logic        pend_is_rd_reg;
  logic [7:0]  wdata_reg;
  logic [7:0]  rdata_reg;
  logic        overrun_reg;

  logic        acc_rd;
  logic        acc_wr;
  logic        acc_addr;
  logic        any_strobe;
  logic        multi_strobe;
  logic        drop;
  logic        new_pend;
  logic        advance;
  logic        ppu_sel;
  logic        latch_w;
  logic        unused_ctrl_bits;

  // Only the increment-select bit of ppu_ctrl1 matters here.
  assign unused_ctrl_bits = ^{ppu_ctrl1[7:3], ppu_ctrl1[1:0], latch_w};

  // ---------------------------------------------------------------------------
  // Strobe acceptance: nothing is accepted while busy; otherwise only the
  // highest-priority strobe (data_rd > data_wr > addr_wr) goes through.
  // ---------------------------------------------------------------------------
  assign any_strobe   = cpu_addr_wr | cpu_data_wr | cpu_data_rd;
  assign multi_strobe = (cpu_data_rd & cpu_data_wr) |
                        (cpu_data_rd & cpu_addr_wr) |
                        (cpu_data_wr & cpu_addr_wr);
  assign acc_rd   = cpu_data_rd & ~pend_valid_reg;
  assign acc_wr   = cpu_data_wr & ~cpu_data_rd & ~pend_valid_reg;
  assign acc_addr = cpu_addr_wr & ~cpu_data_wr & ~cpu_data_rd & ~pend_valid_reg;
  assign drop     = (pend_valid_reg & any_strobe) | multi_strobe;
  assign new_pend = acc_rd | acc_wr;

  // The address steps once per completed $2007 access.
  assign advance = (state_reg == S_CPU_WR) | (state_reg == S_CPU_RD_CAP);

  ppu_cpu_addr_latch #(
    .ADDR_MASK (ADDR_MASK),
    .INC_BIG   (INC_BIG)
  ) u_addr_latch (
    .clk         (clk),
    .rst         (rst),
    .addr_wr     (acc_addr),
    .status_rd   (cpu_status_rd),
    .wdata       (cpu_wdata),
    .inc_big_sel (ppu_ctrl1[2]),
    .advance     (advance),
    .vaddr       (cpu_vaddr),
    .w           (latch_w)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A strobe accepted this cycle may start immediately when
  // the PPU is not asking, which gives the one-cycle strobe-to-access latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (!ppu_req && pend_valid_reg) begin
          state_next = pend_is_rd_reg ? S_CPU_RD : S_CPU_WR;
        end else if (!ppu_req && new_pend) begin
          state_next = acc_rd ? S_CPU_RD : S_CPU_WR;
        end
      end
      S_CPU_WR:     state_next = S_IDLE;
      S_CPU_RD:     state_next = S_CPU_RD_CAP;
      S_CPU_RD_CAP: state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The PPU path is gated by rst so that grant and address read
  // as zero while reset is held, even if ppu_req is already high.
  // ---------------------------------------------------------------------------
  assign ppu_sel = ppu_req & rst;

  always_comb begin
    ppu_grant = 1'b0;
    vram_addr = cpu_vaddr;
    vram_we   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        ppu_grant = ppu_sel;
        vram_addr = ppu_sel ? ppu_addr : cpu_vaddr;
      end
      S_CPU_WR: begin
        vram_we = 1'b1;
      end
      default: begin
        vram_we = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending slot, write byte, read buffer, overrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_reg <= 1'b0;
      pend_is_rd_reg <= 1'b0;
      wdata_reg      <= 8'h00;
      rdata_reg      <= 8'h00;
      overrun_reg    <= 1'b0;
    end else begin
      if (advance) begin
        pend_valid_reg <= 1'b0;
      end else if (new_pend) begin
        pend_valid_reg <= 1'b1;
        pend_is_rd_reg <= acc_rd;
      end
      if (acc_wr) begin
        wdata_reg <= cpu_wdata;
      end
      if (state_reg == S_CPU_RD_CAP) begin
        rdata_reg <= vram_data_in;
      end
      overrun_reg <= overrun_reg | drop;
    end
  end

  assign vram_data_out = wdata_reg;
  assign cpu_rdata     = rdata_reg;
  assign cpu_busy      = pend_valid_reg;
  assign cpu_overrun   = overrun_reg;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
module tb_ppu_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        ppu_req;
  logic [15:0] ppu_addr;
  logic        ppu_grant;
  logic        cpu_addr_wr;
  logic        cpu_data_wr;
  logic        cpu_data_rd;
  logic        cpu_status_rd;
  logic [7:0]  cpu_wdata;
  logic [7:0]  ppu_ctrl1;
  logic [7:0]  cpu_rdata;
  logic        cpu_busy;
  logic        cpu_overrun;
  logic [15:0] cpu_vaddr;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_data_out;
  logic [7:0]  vram_data_in;

  int checks;
  int failures;

  ppu_vram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .ppu_req       (ppu_req),
    .ppu_addr      (ppu_addr),
    .ppu_grant     (ppu_grant),
    .cpu_addr_wr   (cpu_addr_wr),
    .cpu_data_wr   (cpu_data_wr),
    .cpu_data_rd   (cpu_data_rd),
    .cpu_status_rd (cpu_status_rd),
    .cpu_wdata     (cpu_wdata),
    .ppu_ctrl1     (ppu_ctrl1),
    .cpu_rdata     (cpu_rdata),
    .cpu_busy      (cpu_busy),
    .cpu_overrun   (cpu_overrun),
    .cpu_vaddr     (cpu_vaddr),
    .vram_addr     (vram_addr),
    .vram_we       (vram_we),
    .vram_data_out (vram_data_out),
    .vram_data_in  (vram_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read VRAM model with a write log.
  logic [7:0]  mem [0:16383];
  int          wr_count;
  logic [15:0] last_wr_addr;
  logic [7:0]  last_wr_data;

  initial begin
    wr_count     = 0;
    last_wr_addr = 16'h0000;
    last_wr_data = 8'h00;
    vram_data_in = 8'h00;
  end

  always @(posedge clk) begin
    if (vram_we) begin
      mem[vram_addr[13:0]] <= vram_data_out;
      wr_count             <= wr_count + 1;
      last_wr_addr         <= vram_addr;
      last_wr_data         <= vram_data_out;
    end
    vram_data_in <= mem[vram_addr[13:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_addr(input logic [7:0] d);
    cpu_addr_wr = 1'b1;
    cpu_wdata   = d;
    step();
    cpu_addr_wr = 1'b0;
  endtask

  task automatic set_vaddr(input logic [7:0] hi, input logic [7:0] lo);
    strobe_addr(hi);
    strobe_addr(lo);
  endtask

  // Plain $2007 write with no PPU traffic; leaves the bench two cycles later.
  task automatic cpu_write(input logic [7:0] d);
    cpu_data_wr = 1'b1;
    cpu_wdata   = d;
    step();
    cpu_data_wr = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ppu_req = 1'b1;
    ppu_addr = 16'h1234;
    #1;
    checks++; if (ppu_grant !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b want=0", ppu_grant); end
    checks++; if (vram_addr !== 16'h0000) begin failures++; $display("FAIL reset_vram_addr got=%h want=0000", vram_addr); end
    step();
    ppu_req = 1'b0;
    #1;
    checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", vram_we); end
    checks++; if (vram_data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h want=00", vram_data_out); end
    checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h want=00", cpu_rdata); end
    checks++; if (cpu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", cpu_busy); end
    checks++; if (cpu_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", cpu_overrun); end
    checks++; if (cpu_vaddr !== 16'h0000) begin failures++; $display("FAIL reset_vaddr got=%h want=0000", cpu_vaddr); end
    rst = 1'b1;
    step();
    $display("reset: outputs checked");
  endtask

  task automatic test_write_basic();
    ppu_ctrl1 = 8'h00;
    set_vaddr(8'h21, 8'h08);
    checks++; if (cpu_vaddr !== 16'h2108) begin failures++; $display("FAIL wr_set_vaddr got=%h want=2108", cpu_vaddr); end
    cpu_data_wr = 1'b1;
    cpu_wdata   = 8'hAB;
    step();
    cpu_data_wr = 1'b0;
    #1;
    checks++; if (vram_we !== 1'b1) begin failures++; $display("FAIL wr_we got=%b want=1", vram_we); end
    checks++; if (vram_addr !== 16'h2108) begin failures++; $display("FAIL wr_addr got=%h want=2108", vram_addr); end
    checks++; if (vram_data_out !== 8'hAB) begin failures++; $display("FAIL wr_data got=%h want=AB", vram_data_out); end
    checks++; if (cpu_busy !== 1'b1) begin failures++; $display("FAIL wr_busy_n1 got=%b want=1", cpu_busy); end
    step();
    checks++; if (cpu_busy !== 1'b0) begin failures++; $display("FAIL wr_busy_n2 got=%b want=0", cpu_busy); end
    checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL wr_we_n2 got=%b want=0", vram_we); end
    checks++; if (cpu_vaddr !== 16'h2109) begin failures++; $display("FAIL wr_vaddr_inc got=%h want=2109", cpu_vaddr); end
    checks++; if (last_wr_addr !== 16'h2108 || last_wr_data !== 8'hAB) begin failures++; $display("FAIL wr_mem got=%h/%h want=2108/AB", last_wr_addr, last_wr_data); end
    $display("write_basic: $2007 write AB at 2108");
  endtask

  task automatic test_wrap();
    ppu_ctrl1 = 8'h04;
    set_vaddr(8'h3F, 8'hF0);
    cpu_data_wr = 1'b1;
    cpu_wdata   = 8'h5A;
    step();
    cpu_data_wr = 1'b0;
    #1;
    checks++; if (vram_addr !== 16'h3FF0) begin failures++; $display("FAIL wrap32_addr got=%h want=3FF0", vram_addr); end
    step();
    checks++; if (cpu_vaddr !== 16'h0010) begin failures++; $display("FAIL wrap32_vaddr got=%h want=0010", cpu_vaddr); end
    ppu_ctrl1 = 8'h00;
    set_vaddr(8'h3F, 8'hFF);
    cpu_write(8'h66);
    checks++; if (cpu_vaddr !== 16'h0000) begin failures++; $display("FAIL wrap1_vaddr got=%h want=0000", cpu_vaddr); end
    checks++; if (last_wr_addr !== 16'h3FFF) begin failures++; $display("FAIL wrap1_addr got=%h want=3FFF", last_wr_addr); end
    $display("wrap: increments of 32 and 1 wrapped");
  endtask

  task automatic test_reset_mid_op();
    int cnt;
    set_vaddr(8'h01, 8'h00);
    cnt = wr_count;
    cpu_data_wr = 1'b1;
    cpu_wdata   = 8'hEE;
    step();
    cpu_data_wr = 1'b0;
    #1;
    checks++; if (vram_we !== 1'b1) begin failures++; $display("FAIL midrst_inflight got=%b want=1", vram_we); end
    rst = 1'b0;
    #1;
    checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL midrst_we got=%b want=0", vram_we); end
    checks++; if (cpu_busy !== 1'b0 || cpu_vaddr !== 16'h0000) begin failures++; $display("FAIL midrst_state got=%b/%h want=0/0000", cpu_busy, cpu_vaddr); end
    step();
    rst = 1'b1;
    step();
    checks++; if (wr_count !== cnt) begin failures++; $display("FAIL midrst_no_write got=%0d want=%0d", wr_count, cnt); end
    $display("reset_mid_op: in-flight write abandoned");
  endtask

  task automatic test_read_buffer();
    ppu_ctrl1 = 8'h00;
    set_vaddr(8'h20, 8'h00);
    cpu_write(8'h11);
    cpu_write(8'h22);
    set_vaddr(8'h20, 8'h00);
    checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL rd1_stale got=%h want=00", cpu_rdata); end
    cpu_data_rd = 1'b1;
    step();
    cpu_data_rd = 1'b0;
    #1;
    checks++; if (vram_addr !== 16'h2000 || cpu_busy !== 1'b1) begin failures++; $display("FAIL rd1_addr got=%h/%b want=2000/1", vram_addr, cpu_busy); end
    step();
    checks++; if (cpu_busy !== 1'b1) begin failures++; $display("FAIL rd1_busy_n2 got=%b want=1", cpu_busy); end
    step();
    checks++; if (cpu_rdata !== 8'h11) begin failures++; $display("FAIL rd1_fill got=%h want=11", cpu_rdata); end
    checks++; if (cpu_busy !== 1'b0 || cpu_vaddr !== 16'h2001) begin failures++; $display("FAIL rd1_done got=%b/%h want=0/2001", cpu_busy, cpu_vaddr); end
    cpu_data_rd = 1'b1;
    step();
    cpu_data_rd = 1'b0;
    step();
    step();
    checks++; if (cpu_rdata !== 8'h22) begin failures++; $display("FAIL rd2_fill got=%h want=22", cpu_rdata); end
    $display("read_buffer: 00 then 11, buffer now 22");
  endtask

  task automatic test_back_to_back();
    ppu_req  = 1'b1;
    ppu_addr = 16'h2000;
    #1;
    checks++; if (ppu_grant !== 1'b1 || vram_addr !== 16'h2000) begin failures++; $display("FAIL b2b_grant got=%b/%h want=1/2000", ppu_grant, vram_addr); end
    step();
    ppu_addr = 16'h2001;
    #1;
    checks++; if (vram_data_in !== 8'h11) begin failures++; $display("FAIL b2b_data0 got=%h want=11", vram_data_in); end
    step();
    ppu_req = 1'b0;
    #1;
    checks++; if (vram_data_in !== 8'h22) begin failures++; $display("FAIL b2b_data1 got=%h want=22", vram_data_in); end
    $display("back_to_back: two PPU reads in consecutive cycles");
  endtask

  task automatic test_ppu_priority();
    int cnt;
    int bad;
    set_vaddr(8'h22, 8'h00);
    cnt = wr_count;
    bad = 0;
    ppu_req  = 1'b1;
    ppu_addr = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      cpu_data_wr = (i == 0);
      cpu_wdata   = 8'h77;
      #1;
      if (ppu_grant !== 1'b1 || vram_we !== 1'b0 || vram_addr !== 16'h1234) bad++;
      step();
    end
    cpu_data_wr = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL prio_hold bad_cycles=%0d want=0", bad); end
    ppu_req = 1'b0;
    #1;
    checks++; if (vram_we !== 1'b0 || cpu_busy !== 1'b1) begin failures++; $display("FAIL prio_fall got=%b/%b want=0/1", vram_we, cpu_busy); end
    step();
    checks++; if (vram_we !== 1'b1 || vram_addr !== 16'h2200 || vram_data_out !== 8'h77) begin failures++; $display("FAIL prio_exec got=%b/%h/%h want=1/2200/77", vram_we, vram_addr, vram_data_out); end
    checks++; if (ppu_grant !== 1'b0) begin failures++; $display("FAIL prio_nogrant got=%b want=0", ppu_grant); end
    step();
    checks++; if (wr_count !== cnt + 1 || cpu_busy !== 1'b0) begin failures++; $display("FAIL prio_done got=%0d/%b want=%0d/0", wr_count, cpu_busy, cnt + 1); end
    $display("ppu_priority: write waited 10 PPU cycles");
  endtask

  task automatic test_toggle();
    strobe_addr(8'h12);
    cpu_status_rd = 1'b1;
    step();
    cpu_status_rd = 1'b0;
    strobe_addr(8'h3F);
    checks++; if (cpu_vaddr[13:8] !== 6'h3F) begin failures++; $display("FAIL tog_hi got=%h want=3F", cpu_vaddr[13:8]); end
    strobe_addr(8'h45);
    checks++; if (cpu_vaddr !== 16'h3F45) begin failures++; $display("FAIL tog_lo got=%h want=3F45", cpu_vaddr); end
    strobe_addr(8'h11);
    cpu_status_rd = 1'b1;
    strobe_addr(8'h05);
    cpu_status_rd = 1'b0;
    checks++; if (cpu_vaddr !== 16'h0545) begin failures++; $display("FAIL tog_same_cycle got=%h want=0545", cpu_vaddr); end
    strobe_addr(8'h67);
    checks++; if (cpu_vaddr !== 16'h0567) begin failures++; $display("FAIL tog_after got=%h want=0567", cpu_vaddr); end
    $display("toggle: $2002 clears w");
  endtask

  task automatic test_overrun();
    int cnt;
    set_vaddr(8'h03, 8'h00);
    cnt = wr_count;
    cpu_data_wr = 1'b1;
    cpu_wdata   = 8'h99;
    step();
    cpu_wdata   = 8'h55;
    #1;
    checks++; if (cpu_overrun !== 1'b0 || vram_we !== 1'b1) begin failures++; $display("FAIL ovr_pre got=%b/%b want=0/1", cpu_overrun, vram_we); end
    step();
    cpu_data_wr = 1'b0;
    checks++; if (cpu_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b want=1", cpu_overrun); end
    checks++; if (wr_count !== cnt + 1 || last_wr_data !== 8'h99) begin failures++; $display("FAIL ovr_first got=%0d/%h want=%0d/99", wr_count, last_wr_data, cnt + 1); end
    repeat (5) step();
    checks++; if (cpu_overrun !== 1'b1 || wr_count !== cnt + 1) begin failures++; $display("FAIL ovr_sticky got=%b/%0d want=1/%0d", cpu_overrun, wr_count, cnt + 1); end
    $display("overrun: second write dropped");
  endtask

  task automatic test_multi_strobe();
    int cnt;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    cnt = wr_count;
    cpu_data_rd = 1'b1;
    cpu_data_wr = 1'b1;
    cpu_wdata   = 8'hC3;
    step();
    cpu_data_rd = 1'b0;
    cpu_data_wr = 1'b0;
    #1;
    checks++; if (cpu_busy !== 1'b1 || vram_we !== 1'b0) begin failures++; $display("FAIL multi_read_won got=%b/%b want=1/0", cpu_busy, vram_we); end
    checks++; if (cpu_overrun !== 1'b1) begin failures++; $display("FAIL multi_overrun got=%b want=1", cpu_overrun); end
    step();
    step();
    checks++; if (cpu_busy !== 1'b0 || wr_count !== cnt || cpu_vaddr !== 16'h0001) begin failures++; $display("FAIL multi_done got=%b/%0d/%h want=0/%0d/0001", cpu_busy, wr_count, cpu_vaddr, cnt); end
    $display("multi_strobe: read beat write");
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    ppu_req       = 1'b0;
    ppu_addr      = 16'h0000;
    cpu_addr_wr   = 1'b0;
    cpu_data_wr   = 1'b0;
    cpu_data_rd   = 1'b0;
    cpu_status_rd = 1'b0;
    cpu_wdata     = 8'h00;
    ppu_ctrl1     = 8'h00;
    test_reset();
    test_write_basic();
    test_wrap();
    test_reset_mid_op();
    test_read_buffer();
    test_back_to_back();
    test_ppu_priority();
    test_toggle();
    test_overrun();
    test_multi_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
